// File: rtl/stack_op_sequencer.sv
// Stack-group instruction sequencer: owns SP and drives the byte-wide data-memory
// port, register write-back and PC load for PUSH, POP, RCALL and RET.
module stack_op_sequencer #(
    parameter int         PC_WIDTH     = 10,
    parameter logic [7:0] SP_INIT      = 8'hBF,
    parameter int         OPCODE_COUNT = 8,
    parameter int         TYPE_PUSH    = 1,
    parameter int         TYPE_POP     = 2,
    parameter int         TYPE_RCALL   = 3,
    parameter int         TYPE_RET     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    instr_valid,
    input  logic [OPCODE_COUNT-1:0] opcode_type,
    input  logic [11:0]             opcode_imd,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [7:0]              rr_data,
    input  logic [7:0]              mem_rdata,
    output logic                    ready,
    output logic [7:0]              mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic                    rd_we,
    output logic [7:0]              rd_wdata,
    output logic                    pc_load,
    output logic [PC_WIDTH-1:0]     pc_next,
    output logic [7:0]              sp,
    output logic                    done
);

    typedef enum logic [3:0] {
        IDLE, PUSH_WR, POP_RD, POP_WB, CALL_LO, CALL_HI, RET_HI, RET_LO, RET_END
    } state_t;

    localparam logic [OPCODE_COUNT-1:0] SEL_PUSH   = OPCODE_COUNT'(1) << TYPE_PUSH;
    localparam logic [OPCODE_COUNT-1:0] SEL_POP    = OPCODE_COUNT'(1) << TYPE_POP;
    localparam logic [OPCODE_COUNT-1:0] SEL_RCALL  = OPCODE_COUNT'(1) << TYPE_RCALL;
    localparam logic [OPCODE_COUNT-1:0] SEL_RET    = OPCODE_COUNT'(1) << TYPE_RET;
    localparam logic [OPCODE_COUNT-1:0] STACK_MASK = SEL_PUSH | SEL_POP | SEL_RCALL | SEL_RET;

    state_t                state, state_nxt;
    logic [7:0]            sp_q, sp_nxt;
    logic [PC_WIDTH-1:0]   ret_q;
    logic [11:0]           k_q;
    logic [7:0]            rr_q;
    logic [7:0]            hi_q;
    logic [PC_WIDTH-1:0]   k_ext;

    // Signed cast sign-extends (or truncates) k to the PC width; the add then wraps.
    assign k_ext = PC_WIDTH'($signed(k_q));
    assign sp    = sp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sp_q  <= SP_INIT;
            ret_q <= '0;
            k_q   <= '0;
            rr_q  <= '0;
            hi_q  <= '0;
        end else begin
            state <= state_nxt;
            sp_q  <= sp_nxt;
            if (state == IDLE && state_nxt != IDLE) begin
                ret_q <= pc + PC_WIDTH'(1);
                k_q   <= opcode_imd;
                rr_q  <= rr_data;
            end
            // Return-address high byte arrives the cycle after RET_HI's read.
            if (state == RET_LO)
                hi_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        sp_nxt    = sp_q;
        ready     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        rd_we     = 1'b0;
        rd_wdata  = '0;
        pc_load   = 1'b0;
        pc_next   = '0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (instr_valid) begin
                    case (opcode_type & STACK_MASK)
                        SEL_PUSH:  state_nxt = PUSH_WR;
                        SEL_POP:   state_nxt = POP_RD;
                        SEL_RCALL: state_nxt = CALL_LO;
                        SEL_RET:   state_nxt = RET_HI;
                        default:   state_nxt = IDLE;
                    endcase
                end
            end
            PUSH_WR: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = rr_q;
                done      = 1'b1;
                sp_nxt    = sp_q - 8'd1;
                state_nxt = IDLE;
            end
            POP_RD: begin
                mem_re    = 1'b1;
                mem_addr  = sp_q + 8'd1;
                sp_nxt    = sp_q + 8'd1;
                state_nxt = POP_WB;
            end
            POP_WB: begin
                rd_we     = 1'b1;
                rd_wdata  = mem_rdata;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            CALL_LO: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = ret_q[7:0];
                sp_nxt    = sp_q - 8'd1;
                state_nxt = CALL_HI;
            end
            CALL_HI: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = 8'(ret_q >> 8);
                sp_nxt    = sp_q - 8'd1;
                pc_load   = 1'b1;
                pc_next   = ret_q + k_ext;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            RET_HI: begin
                mem_re    = 1'b1;
                mem_addr  = sp_q + 8'd1;
                sp_nxt    = sp_q + 8'd1;
                state_nxt = RET_LO;
            end
            RET_LO: begin
                mem_re    = 1'b1;
                mem_addr  = sp_q + 8'd1;
                sp_nxt    = sp_q + 8'd1;
                state_nxt = RET_END;
            end
            RET_END: begin
                pc_load   = 1'b1;
                pc_next   = PC_WIDTH'({hi_q, mem_rdata});
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: vector table of stack instructions, memory model,
// and a scoreboard of expected memory/write-back/PC-load events.
module tb_stack_op_sequencer;

    localparam int PCW = 10;
    localparam int T_ADD = 0, T_PUSH = 1, T_POP = 2, T_RCALL = 3, T_RET = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            instr_valid;
    logic [7:0]      opcode_type;
    logic [11:0]     opcode_imd;
    logic [PCW-1:0]  pc;
    logic [7:0]      rr_data;
    logic [7:0]      mem_rdata;
    logic            ready;
    logic [7:0]      mem_addr;
    logic [7:0]      mem_wdata;
    logic            mem_we;
    logic            mem_re;
    logic            rd_we;
    logic [7:0]      rd_wdata;
    logic            pc_load;
    logic [PCW-1:0]  pc_next;
    logic [7:0]      sp;
    logic            done;

    stack_op_sequencer #(.PC_WIDTH(PCW), .SP_INIT(8'hBF)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode_type(opcode_type),
        .opcode_imd(opcode_imd), .pc(pc), .rr_data(rr_data), .mem_rdata(mem_rdata),
        .ready(ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .rd_we(rd_we), .rd_wdata(rd_wdata), .pc_load(pc_load),
        .pc_next(pc_next), .sp(sp), .done(done)
    );

    always #5 clk = ~clk;

    // Data memory: read data valid the cycle after mem_re.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_addr] : 8'h00;
    end

    typedef struct {
        int             typ;
        logic [PCW-1:0] pc;
        logic [11:0]    k;
        logic [7:0]     rr;
        int             cyc;
        logic [7:0]     sp;
        logic [PCW-1:0] pcn;
        logic [7:0]     rd;
    } vec_t;

    // kind: 0 write, 1 read, 2 reg write-back, 3 pc load
    typedef struct {
        logic [1:0]     kind;
        logic [7:0]     a;
        logic [PCW-1:0] d;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         passes = 0;
    logic       sb_en  = 1'b0;
    logic [7:0] tb_sp;
    vec_t       vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cmp_ev(input logic [1:0] kind, input logic [7:0] a, input logic [PCW-1:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("event", {12'h0, kind, a, d}, {12'h0, e.kind, e.a, e.d});
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && !reset) begin
            if (mem_we)  cmp_ev(2'd0, mem_addr, {2'b00, mem_wdata});
            if (mem_re)  cmp_ev(2'd1, mem_addr, '0);
            if (rd_we)   cmp_ev(2'd2, 8'h00, {2'b00, rd_wdata});
            if (pc_load) cmp_ev(2'd3, 8'h00, pc_next);
        end
    end

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] a, input logic [PCW-1:0] d);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic got;
        logic [PCW-1:0] ret;
        @(negedge clk);
        chk("ready_before", {31'h0, ready}, 1);
        instr_valid = 1'b1;
        opcode_type = 8'd1 << v.typ;
        pc          = v.pc;
        opcode_imd  = v.k;
        rr_data     = v.rr;
        case (v.typ)
            T_PUSH: begin push_ev(0, tb_sp, {2'b00, v.rr}); tb_sp--; end
            T_POP: begin
                push_ev(1, tb_sp + 8'd1, '0); tb_sp++;
                push_ev(2, 8'h00, {2'b00, v.rd});
            end
            T_RCALL: begin
                ret = v.pc + 10'd1;
                push_ev(0, tb_sp, {2'b00, ret[7:0]}); tb_sp--;
                push_ev(0, tb_sp, {8'h00, ret[9:8]}); tb_sp--;
                push_ev(3, 8'h00, v.pcn);
            end
            T_RET: begin
                push_ev(1, tb_sp + 8'd1, '0); tb_sp++;
                push_ev(1, tb_sp + 8'd1, '0); tb_sp++;
                push_ev(3, 8'h00, v.pcn);
            end
            default: ;
        endcase
        @(posedge clk); #1;
        // Busy-time noise: a PUSH request that must be ignored.
        if (v.cyc > 0) begin
            opcode_type = 8'd1 << T_PUSH;
            rr_data     = 8'hEE;
            pc          = '0;
        end
        n = 0; got = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (done) begin n = c; got = 1'b1; end
        end
        instr_valid = 1'b0;
        chk("cycles", n, v.cyc);
        @(posedge clk); #1;
        chk("sp_after", {24'h0, sp}, {24'h0, v.sp});
    endtask

    initial begin
        vec_t w;
        vt[0]  = '{T_ADD,   10'h000, 12'h000, 8'h00, 0, 8'hBF, 10'h000, 8'h00};
        vt[1]  = '{T_PUSH,  10'h000, 12'h000, 8'h5A, 1, 8'hBE, 10'h000, 8'h00};
        vt[2]  = '{T_POP,   10'h000, 12'h000, 8'h00, 2, 8'hBF, 10'h000, 8'h5A};
        vt[3]  = '{T_RCALL, 10'h123, 12'hFFE, 8'h00, 2, 8'hBD, 10'h122, 8'h00};
        vt[4]  = '{T_RET,   10'h000, 12'h000, 8'h00, 3, 8'hBF, 10'h124, 8'h00};
        vt[5]  = '{T_PUSH,  10'h000, 12'h000, 8'hA5, 1, 8'hBE, 10'h000, 8'h00};
        vt[6]  = '{T_PUSH,  10'h000, 12'h000, 8'h3C, 1, 8'hBD, 10'h000, 8'h00};
        vt[7]  = '{T_POP,   10'h000, 12'h000, 8'h00, 2, 8'hBE, 10'h000, 8'h3C};
        vt[8]  = '{T_POP,   10'h000, 12'h000, 8'h00, 2, 8'hBF, 10'h000, 8'hA5};
        vt[9]  = '{T_RCALL, 10'h3FF, 12'h001, 8'h00, 2, 8'hBD, 10'h001, 8'h00};
        vt[10] = '{T_RET,   10'h000, 12'h000, 8'h00, 3, 8'hBF, 10'h000, 8'h00};
        vt[11] = '{T_RCALL, 10'h2FE, 12'h7FF, 8'h00, 2, 8'hBD, 10'h2FE, 8'h00};
        vt[12] = '{T_RET,   10'h000, 12'h000, 8'h00, 3, 8'hBF, 10'h2FF, 8'h00};
        vt[13] = '{T_RCALL, 10'h010, 12'h005, 8'h00, 2, 8'hBD, 10'h016, 8'h00};
        vt[14] = '{T_RET,   10'h000, 12'h000, 8'h00, 3, 8'hBF, 10'h011, 8'h00};

        reset = 1'b1; instr_valid = 1'b0; opcode_type = '0; opcode_imd = '0;
        pc = '0; rr_data = '0;
        tb_sp = 8'hBF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sp", {24'h0, sp}, 32'hBF);
        chk("rst_ready", {31'h0, ready}, 1);
        chk("rst_strobes", {27'h0, mem_we, mem_re, rd_we, pc_load, done}, 0);
        chk("rst_data", {mem_addr, mem_wdata, rd_wdata, pc_next[7:0]}, 0);
        reset = 1'b0;
        sb_en = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vt[i]);

        // Reset while in CALL_HI aborts the call immediately.
        sb_en = 1'b0;
        @(negedge clk);
        instr_valid = 1'b1; opcode_type = 8'd1 << T_RCALL; pc = 10'h050; opcode_imd = 12'h000;
        @(posedge clk); #1;
        opcode_type = 8'd1 << T_PUSH;
        @(negedge clk);
        chk("call_lo_we", {23'h0, mem_we, mem_addr}, {23'h0, 1'b1, 8'hBF});
        @(posedge clk); #1;
        chk("call_hi_we", {22'h0, mem_we, pc_load, mem_addr}, {22'h0, 2'b11, 8'hBE});
        reset = 1'b1;
        #1;
        chk("abort_strobes", {27'h0, mem_we, mem_re, rd_we, pc_load, done}, 0);
        chk("abort_sp", {24'h0, sp}, 32'hBF);
        chk("abort_ready", {31'h0, ready}, 1);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tb_sp = 8'hBF;

        // 65 POPs carry SP from 0xBF through 0xFF to 0x00.
        for (int i = 0; i < 65; i++) begin
            w = '{T_POP, 10'h000, 12'h000, 8'h00, 2, 8'(8'hBF + i + 1), 10'h000, 8'h00};
            run_vec(w);
        end
        exp_q.delete();
        sb_en = 1'b1;
        w = '{T_PUSH, 10'h000, 12'h000, 8'h77, 1, 8'hFF, 10'h000, 8'h00};
        run_vec(w);
        w = '{T_POP, 10'h000, 12'h000, 8'h00, 2, 8'h00, 10'h000, 8'h77};
        run_vec(w);
        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
